// File: rtl/vram_blitter_if.sv
// vram_blitter_if: command, source-read and framebuffer-write bus of the blitter.
// slave  = blitter side, master = command issuer / memory side.
interface vram_blitter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 13
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_x;
    logic [7:0]        cmd_y;
    logic [7:0]        cmd_w;
    logic [7:0]        cmd_h;
    logic [ADDR_W-1:0] cmd_src;
    logic              src_en;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_data;
    logic              dst_we;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst_data;
    logic              busy;
    logic              done;

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_src, src_data,
        output cmd_ready, src_en, src_addr, dst_we, dst_addr, dst_data, busy, done
    );

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_src, src_data,
        input  cmd_ready, src_en, src_addr, dst_we, dst_addr, dst_data, busy, done
    );
endinterface

// File: rtl/vram_blitter.sv
// vram_blitter: copies a w x h sprite from a source read port into framebuffer
// VRAM at (x, y), one pixel per cycle, skipping transparent pixels (alpha = 0).
// Build option: define BLIT_CLIP_EN to drop writes that fall outside the
// framebuffer; otherwise out-of-range coordinates wrap into the linear address.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | one source read per cycle, (col,row) tag advances
// DRAIN | reads finished, last two pixels still in the write pipe
// DONE  | one-cycle completion pulse
module vram_blitter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 13,
    parameter int FB_W   = 160,
    parameter int FB_H   = 120
) (
    input  logic          i_clk,
    input  logic          i_rst,
    vram_blitter_if.slave bus
);

`ifdef BLIT_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_x;
    logic [7:0]        r_y;
    logic [7:0]        r_w;
    logic [7:0]        r_h;
    logic [7:0]        r_col;
    logic [7:0]        r_row;
    logic              r_src_en;
    logic [ADDR_W-1:0] r_src_addr;
    logic              r_drain_cnt;
    logic              r_d_vld;
    logic [7:0]        r_d_col;
    logic [7:0]        r_d_row;
    logic              r_dst_we;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [DATA_W-1:0] r_dst_data;

    logic              w_last;
    logic [8:0]        w_sx;
    logic [8:0]        w_sy;
    logic [ADDR_W-1:0] w_lin;
    logic              w_in_bounds;

    // Last read of the rectangle and screen position of the pixel in the data stage.
    // The linear address is formed in ADDR_W bits, which is the required modulo.
    always_comb begin
        w_last      = (r_col == r_w - 8'd1) && (r_row == r_h - 8'd1);
        w_sx        = {1'b0, r_x} + {1'b0, r_d_col};
        w_sy        = {1'b0, r_y} + {1'b0, r_d_row};
        w_lin       = ADDR_W'(w_sy) * ADDR_W'(FB_W) + ADDR_W'(w_sx);
        w_in_bounds = !CLIP_EN || ((int'(w_sx) < FB_W) && (int'(w_sy) < FB_H));
    end

    // Command sequencing FSM: latches the command, issues reads, drains, pulses done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_src_en    <= 1'b0;
            r_src_addr  <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_x         <= bus.cmd_x;
                        r_y         <= bus.cmd_y;
                        r_w         <= bus.cmd_w;
                        r_h         <= bus.cmd_h;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_src_addr  <= bus.cmd_src;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.cmd_w == 8'd0 || bus.cmd_h == 8'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_src_en <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_src_en    <= 1'b0;
                        r_drain_cnt <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_src_addr <= r_src_addr + ADDR_W'(1);
                        if (r_col == r_w - 8'd1) begin
                            r_col <= '0;
                            r_row <= r_row + 8'd1;
                        end else begin
                            r_col <= r_col + 8'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == 1'b0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write pipe: read-stage tag moves to the data stage, then the write is registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_d_vld    <= 1'b0;
            r_d_col    <= '0;
            r_d_row    <= '0;
            r_dst_we   <= 1'b0;
            r_dst_addr <= '0;
            r_dst_data <= '0;
        end else begin
            r_d_vld    <= r_src_en;
            r_d_col    <= r_col;
            r_d_row    <= r_row;
            r_dst_we   <= r_d_vld && bus.src_data[0] && w_in_bounds;
            r_dst_addr <= w_lin;
            r_dst_data <= bus.src_data;
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.src_en    = r_src_en;
    assign bus.src_addr  = r_src_addr;
    assign bus.dst_we    = r_dst_we;
    assign bus.dst_addr  = r_dst_addr;
    assign bus.dst_data  = r_dst_data;

endmodule
